// File: rtl/tc_force_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tc_force_seq : queued force/probe sequencer (FIFO -> force -> capture -> gap)
// Rev 1.0
// ============================================================================
module tc_force_seq #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_val,
  input  logic [15:0]  cmd_hold,
  input  logic [7:0]   cmd_gap,
  output logic         force_en,
  output logic [W-1:0] force_val,
  input  logic [W-1:0] probe_in,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FORCE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]      mem_val_q  [DEPTH];
  logic [15:0]       mem_hold_q [DEPTH];
  logic [7:0]        mem_gap_q  [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [15:0]  hold_q, hold_d;
  logic [7:0]   gap_q, gap_d;
  logic [W-1:0] val_q, val_d;
  logic [W-1:0] cap_q, cap_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_valid_q, rsp_valid_d;

  logic push, pop, empty, full, slot_free;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign cmd_ready = !rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign slot_free = !rsp_valid_q || rsp_ready;

  assign wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  assign busy      = (state_q != S_IDLE) || !empty;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    val_d       = val_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    pop         = 1'b0;
    force_en    = 1'b0;
    force_val   = '0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = (mem_hold_q[rd_ptr_q] == 16'd0) ? 16'd1 : mem_hold_q[rd_ptr_q];
          val_d   = mem_val_q[rd_ptr_q];
          gap_d   = mem_gap_q[rd_ptr_q];
          state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        force_en  = 1'b1;
        force_val = val_q;
        // Probe is sampled at the edge closing the last forced cycle
        if (hold_q == 16'd1) begin
          cap_d   = probe_in;
          state_d = S_CAPTURE;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      S_CAPTURE: begin
        if (slot_free) begin
          rsp_data_d  = cap_q;
          rsp_valid_d = 1'b1;
          state_d     = (gap_q != 8'd0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      gap_q       <= '0;
      val_q       <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      val_q       <= val_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Storage needs no reset: a flush only rewinds the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_val_q[wr_ptr_q]  <= cmd_val;
      mem_hold_q[wr_ptr_q] <= cmd_hold;
      mem_gap_q[wr_ptr_q]  <= cmd_gap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tc_force_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for tc_force_seq: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_tc_force_seq;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_val = '0;
  logic [15:0]  cmd_hold = '0;
  logic [7:0]   cmd_gap = '0;
  logic         force_en;
  logic [W-1:0] force_val;
  logic [W-1:0] probe_in = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic         busy;

  tc_force_seq #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_val(cmd_val), .cmd_hold(cmd_hold), .cmd_gap(cmd_gap),
    .force_en(force_en), .force_val(force_val), .probe_in(probe_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Probe and response-sink drivers: fixed values or random per cycle
  logic       prb_rnd = 1'b0;
  logic       rr_rnd = 1'b0;
  logic [7:0] probe_fix = '0;
  logic       rr_fix = 1'b1;

  always begin
    @(posedge clk);
    #2;
    probe_in  = prb_rnd ? 8'($urandom) : probe_fix;
    rsp_ready = rr_rnd ? ($urandom_range(0, 9) < 7) : rr_fix;
  end

  // Reference model: accepted commands queue up, each force window consumes
  // the oldest one, and each window's last-cycle probe becomes the next
  // expected response.
  typedef struct packed {
    logic [7:0]  val;
    logic [15:0] hold;
  } cmd_t;

  cmd_t       cmdq[$];
  logic [7:0] rspq[$];
  cmd_t       cur;
  int         wcnt = 0;
  int         wlen = 1;
  bit         prev_fe = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      cmdq.delete();
      rspq.delete();
      prev_fe    = 1'b0;
      prev_stall = 1'b0;
      wcnt       = 0;
    end else begin
      if (prev_stall)
        chk("rsp_stable", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, prev_data});
      if (force_en) begin
        if (!prev_fe) begin
          wcnt = 0;
          if (cmdq.size() == 0) begin
            chk("window_without_cmd", 32'd1, 32'd0);
          end else begin
            cur  = cmdq.pop_front();
            wlen = (cur.hold == 16'd0) ? 1 : int'(cur.hold);
          end
        end
        wcnt++;
        chk("force_val", {24'd0, force_val}, {24'd0, cur.val});
        if (wcnt == wlen) rspq.push_back(probe_in);
        if (wcnt > wlen) chk("window_overrun", wcnt, wlen);
      end else begin
        chk("idle_force_val", {24'd0, force_val}, 32'd0);
        if (prev_fe) chk("window_len", wcnt, wlen);
      end
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, cmdq.size() < DEPTH});
      if (cmdq.size() != 0 || force_en) chk("busy", {31'd0, busy}, 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (rspq.size() == 0) chk("unexpected_rsp", {24'd0, rsp_data}, 32'hFFFF_FFFF);
        else chk("rsp_data", {24'd0, rsp_data}, {24'd0, rspq.pop_front()});
      end
      if (cmd_valid && cmd_ready) cmdq.push_back({cmd_val, cmd_hold});
      prev_fe    = force_en;
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || rsp_valid || cmdq.size() != 0 || rspq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_idle", {30'd0, busy, rsp_valid}, 32'd0);
    chk("drain_model", cmdq.size() + rspq.size(), 0);
  endtask

  task automatic push_one(input logic [7:0] v, input logic [15:0] h, input logic [7:0] g);
    cmd_val   = v;
    cmd_hold  = h;
    cmd_gap   = g;
    cmd_valid = 1'b1;
    chk("push_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  val;
    logic [15:0] hold;
    logic [7:0]  gap;
    logic [7:0]  probe;
    int          len;
  } vec_t;

  vec_t tbl[5];

  // Back-to-back pair; dead cycles between windows must be capture + gap + idle
  task automatic gap_pair(input logic [7:0] g);
    int n = 0;
    int z = 0;
    wait_idle(100);
    cmd_val = 8'h11; cmd_hold = 16'd2; cmd_gap = g; cmd_valid = 1'b1;
    step();
    cmd_val = 8'h22; cmd_hold = 16'd1; cmd_gap = 8'd0;
    step();
    cmd_valid = 1'b0;
    while (!force_en && n < 20) begin step(); n++; end
    while (force_en && n < 40) begin step(); n++; end
    while (!force_en && n < 60) begin step(); n++; z++; end
    chk($sformatf("gap%0d_dead_cycles", g), z, 2 + int'(g));
    wait_idle(100);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : test
    int   n;
    int   sent;
    bit   acc;
    bit   seen;
    logic [7:0] d;
    logic [10:0] e;
    bit fe_e;

    tbl[0] = '{8'hA5, 16'd3, 8'd0, 8'h3C, 3};
    tbl[1] = '{8'h5A, 16'd0, 8'd0, 8'hC3, 1};
    tbl[2] = '{8'h01, 16'd1, 8'd2, 8'h7E, 1};
    tbl[3] = '{8'hFF, 16'd5, 8'd1, 8'h00, 5};
    tbl[4] = '{8'h80, 16'd2, 8'd4, 8'h81, 2};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("reset_outputs", {8'd0, force_en, force_val, rsp_valid, rsp_data, busy, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    step();

    // Single-command vectors: exact cycle-by-cycle timing from the accept edge
    for (int t = 0; t < 5; t++) begin
      wait_idle(100);
      probe_fix = tbl[t].probe;
      push_one(tbl[t].val, tbl[t].hold, tbl[t].gap);
      for (int i = 0; i <= tbl[t].len + int'(tbl[t].gap) + 3; i++) begin
        fe_e = (i >= 1) && (i <= tbl[t].len);
        e = {fe_e, fe_e ? tbl[t].val : 8'h00, (i == tbl[t].len + 2),
             (i <= tbl[t].len + 1 + int'(tbl[t].gap))};
        chk($sformatf("vec%0d_cyc%0d", t, i),
            {21'd0, force_en, force_val, rsp_valid, busy}, {21'd0, e});
        if (i == tbl[t].len + 2)
          chk($sformatf("vec%0d_rsp_data", t), {24'd0, rsp_data}, {24'd0, tbl[t].probe});
        step();
      end
    end

    gap_pair(8'd0);
    gap_pair(8'd5);

    // Overfill: five commands against a four-deep FIFO while the first runs
    wait_idle(100);
    prb_rnd = 1'b1;
    push_one(8'h31, 16'd10, 8'd0);
    n = 0;
    while (!force_en && n < 10) begin step(); n++; end
    for (int k = 0; k < 4; k++) begin
      push_one(8'h40 + 8'(k), 16'(k), 8'(k % 2));
    end
    chk("full_ready_low", {30'd0, cmd_ready, force_en}, 32'd1);
    cmd_val = 8'h55; cmd_hold = 16'd3; cmd_gap = 8'd0; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    step();
    cmd_valid = 1'b0;
    chk("fifth_waited", {31'd0, n > 0}, 32'd1);
    wait_idle(300);

    // Response back-pressure: second command must park in CAPTURE
    rr_fix = 1'b0;
    cmd_val = 8'h61; cmd_hold = 16'd2; cmd_gap = 8'd0; cmd_valid = 1'b1;
    step();
    cmd_val = 8'h62;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 30) begin step(); n++; end
    chk("stall_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    d = rsp_data;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_rsp_hold", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, d});
    end
    chk("stall_in_capture", {30'd0, force_en, busy}, 32'd1);
    rr_fix = 1'b1;
    wait_idle(100);
    prb_rnd = 1'b0;

    // Reset in the second cycle of an 8-cycle window
    probe_fix = 8'h99;
    push_one(8'h77, 16'd8, 8'd0);
    n = 0;
    while (!force_en && n < 10) begin step(); n++; end
    step();
    chk("pre_reset_forcing", {31'd0, force_en}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_reset_outputs", {19'd0, force_en, force_val, busy, cmd_ready, rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_mid_reset", {31'd0, cmd_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (rsp_valid || force_en || busy) seen = 1'b1;
    end
    chk("no_activity_after_reset", {31'd0, seen}, 32'd0);

    // Randomized traffic against the reference model
    prb_rnd = 1'b1;
    rr_rnd  = 1'b1;
    sent = 0;
    n = 0;
    while (sent < 40 && n < 4000) begin
      if (!cmd_valid && ($urandom_range(0, 1) == 1)) begin
        cmd_val   = 8'($urandom);
        cmd_hold  = 16'($urandom_range(0, 6));
        cmd_gap   = 8'($urandom_range(0, 3));
        cmd_valid = 1'b1;
      end
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      n++;
      if (acc) begin
        sent++;
        cmd_valid = 1'b0;
      end
    end
    chk("rand_all_sent", sent, 40);
    rr_rnd = 1'b0;
    rr_fix = 1'b1;
    wait_idle(1000);
    prb_rnd = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tc_force_seq.md
TC_FORCE_SEQ -- requirements
Module: tc_force_seq

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the width of the force value and the probe value.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the command FIFO depth; DEPTH SHALL be a power of two and at least 2.
REQ-003 Port clk  in  1  is the single clock; all state SHALL update on the rising edge of clk.
REQ-004 Port rst  in  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 Port cmd_valid  in  1  indicates that a command is offered.
REQ-006 Port cmd_ready  out  1  indicates that the command FIFO can accept the offered command.
REQ-007 Port cmd_val  in  W  is the value to force.
REQ-008 Port cmd_hold  in  16  is the number of cycles to force; 0 SHALL be treated as 1.
REQ-009 Port cmd_gap  in  8  is the number of idle cycles inserted after the response is captured.
REQ-010 Port force_en  out  1  is the force enable to the DUT probe point.
REQ-011 Port force_val  out  W  is the forced value, driven only while force_en=1.
REQ-012 Port probe_in  in  W  is the probed DUT value.
REQ-013 Port rsp_valid  out  1  indicates that a response is available.
REQ-014 Port rsp_ready  in  1  indicates that the response sink accepts the response.
REQ-015 Port rsp_data  out  W  is the probe sample taken for a command.
REQ-016 Port busy  out  1  SHALL be 1 whenever the FSM is not in IDLE or the FIFO is not empty.

Function
REQ-017 Command FIFO: cmd_ready SHALL equal !full.
REQ-018 Command FIFO: a push SHALL occur on cmd_valid&&cmd_ready.
REQ-019 Command FIFO: push and pop in the same cycle SHALL leave the occupancy count unchanged.
REQ-020 Command FIFO: pointers SHALL wrap modulo DEPTH.
REQ-021 The FSM states SHALL be IDLE, FORCE, CAPTURE and GAP.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL pop the head, load the hold counter with max(cmd_hold,1), latch the value and gap, and go to FORCE.
REQ-023 In FORCE, force_en SHALL be 1 and force_val SHALL equal the latched value for exactly max(hold,1) consecutive cycles.
REQ-024 On the last FORCE cycle, probe_in SHALL be sampled into the capture register and the FSM SHALL go to CAPTURE.
REQ-025 In CAPTURE, force_en SHALL be 0 and force_val SHALL be 0.
REQ-026 In CAPTURE, when the response slot is free (!rsp_valid || rsp_ready), the capture register SHALL be loaded into rsp_data, rsp_valid SHALL be set on the next edge, and the FSM SHALL go to GAP if gap>0 and to IDLE otherwise.
REQ-027 In CAPTURE, while the response slot is not free, the FSM SHALL wait with no timeout.
REQ-028 GAP SHALL last exactly gap cycles, after which the FSM SHALL return to IDLE.
REQ-029 Response handshake: rsp_valid SHALL stay 1 and rsp_data SHALL stay stable until rsp_valid&&rsp_ready.
REQ-030 Response handshake: a new load in the same cycle as a handshake SHALL replace the old response without a bubble.
REQ-031 Latency: a command accepted at edge T into an empty FIFO with the FSM in IDLE SHALL produce force_en=1 from cycle T+2 through T+1+hold.
REQ-032 Latency: the response for that command SHALL be valid at T+3+hold when the slot is free.
REQ-033 Back-to-back commands with gap=0 SHALL produce exactly one force_en=0 cycle (CAPTURE) and one IDLE cycle between force windows.
REQ-034 Commands SHALL execute and their responses SHALL be returned in FIFO order; there SHALL be no drops and no reordering.

Reset
REQ-035 While rst=1 at an edge, the FSM SHALL go to IDLE, the FIFO SHALL be flushed, and all counters SHALL be cleared.
REQ-036 While rst=1 at an edge, force_en, force_val, rsp_valid, rsp_data, busy and cmd_ready SHALL all be 0.
REQ-037 cmd_ready SHALL become 1 on the first cycle after rst deasserts.
REQ-038 A reset asserted mid-FORCE or mid-CAPTURE SHALL drop force_en at that edge and SHALL discard the pending command and the pending response.

Verification
REQ-039 Single command cmd_val=0xA5, hold=3, gap=0, probe_in=0x3C -> force_en high for 3 cycles with force_val=0xA5, then rsp_data=0x3C and rsp_valid=1 one cycle after the window.
REQ-040 hold=0 -> force window of exactly 1 cycle.
REQ-041 Push 5 commands with DEPTH=4 while the first is executing -> cmd_ready=0 when full, all 5 execute in order, and the responses match in order.
REQ-042 rsp_ready=0 for 10 cycles after the first response -> the FSM holds in CAPTURE for the second command, rsp_data stays stable, and no response is lost.
REQ-043 gap=5 between two commands -> exactly 5 GAP cycles plus 1 IDLE cycle between the CAPTURE of the first command and the force window of the second.
REQ-044 rst asserted in cycle 2 of a hold=8 window -> force_en=0 at the next edge, FIFO empty, and no rsp_valid afterwards.
